// File: rtl/voice_mix_feeder.sv
`default_nettype none
// ============================================================================
// Module   : voice_mix_feeder
// Brief    : Per-voice attack/release gain, sequential mix, 32-bit saturation
//            and FIFO write handshake toward the audio controller.
// Revision : 1.0 - initial release
// ============================================================================
module voice_mix_feeder #(
    parameter int NUM_VOICES   = 10,
    parameter int SAMPLE_DIV   = 1042,
    parameter int ATTACK_STEP  = 16,
    parameter int RELEASE_STEP = 16
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    input  logic [NUM_VOICES-1:0]     voice_en,
    input  logic [32*NUM_VOICES-1:0]  voice_samples,
    input  logic                      audio_out_allowed,
    output logic [31:0]               left_channel_audio_out,
    output logic [31:0]               right_channel_audio_out,
    output logic                      write_audio_out,
    output logic                      sample_dropped
);

    localparam int c_cnt_w = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int c_idx_w = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SAMPLE_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(NUM_VOICES - 1);
    localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);

    localparam logic [16:0] c_gain_max = 17'd256;
    localparam logic [16:0] c_attack   = 17'(ATTACK_STEP);
    localparam logic [16:0] c_release  = 17'(RELEASE_STEP);

    localparam logic signed [39:0] c_acc_max = 40'sh00_7FFF_FFFF;
    localparam logic signed [39:0] c_acc_min = 40'shFF_8000_0000;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_accum = 2'd1;
    localparam logic [1:0] c_st_sat   = 2'd2;
    localparam logic [1:0] c_st_wait  = 2'd3;

    logic [1:0]               state_q, state_d;
    logic [c_cnt_w-1:0]       cnt_q, cnt_d;
    logic [c_idx_w-1:0]       idx_q, idx_d;
    logic signed [39:0]       acc_q, acc_d;
    logic [31:0]              out_q, out_d;

    logic                     w_tick;
    logic                     w_start;
    logic [9*NUM_VOICES-1:0]  w_gains;
    logic [31:0]              w_sample;
    logic [8:0]               w_gain;
    logic signed [41:0]       w_prod;
    logic signed [39:0]       w_term;
    logic [31:0]              w_sat;

    assign w_tick = (cnt_q == c_cnt_last);

    // Gains move once per sample tick and clamp at 0 and unity (256).
    genvar gi;
    generate
        for (gi = 0; gi < NUM_VOICES; gi++) begin : g_gain
            logic [8:0]  gain_q, gain_d;
            logic [16:0] w_cur, w_up;

            assign w_cur = {8'd0, gain_q};
            assign w_up  = w_cur + c_attack;

            always_comb begin
                gain_d = gain_q;
                if (w_tick) begin
                    if (voice_en[gi]) begin
                        gain_d = (w_up > c_gain_max) ? 9'd256 : 9'(w_up);
                    end else begin
                        gain_d = (w_cur <= c_release) ? 9'd0 : 9'(w_cur - c_release);
                    end
                end
            end

            always_ff @(posedge CLOCK_50) begin
                if (reset) begin
                    gain_q <= 9'd0;
                end else begin
                    gain_q <= gain_d;
                end
            end

            assign w_gains[9*gi +: 9] = gain_q;
        end
    endgenerate

    always_comb begin
        w_sample = 32'd0;
        w_gain   = 9'd0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (idx_q == c_idx_w'(i)) begin
                w_sample = voice_samples[32*i +: 32];
                w_gain   = w_gains[9*i +: 9];
            end
        end
    end

    assign w_prod = 42'($signed(w_sample)) * 42'($signed({1'b0, w_gain}));
    assign w_term = 40'(w_prod >>> 8);

    always_comb begin
        if (acc_q > c_acc_max) begin
            w_sat = 32'h7FFF_FFFF;
        end else if (acc_q < c_acc_min) begin
            w_sat = 32'h8000_0000;
        end else begin
            w_sat = acc_q[31:0];
        end
    end

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= c_st_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a tick in WAIT always restarts accumulation
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle:  if (w_tick) state_d = c_st_accum;
            c_st_accum: if (idx_q == c_idx_last) state_d = c_st_sat;
            c_st_sat:   state_d = c_st_wait;
            c_st_wait: begin
                if (w_tick) begin
                    state_d = c_st_accum;
                end else if (audio_out_allowed) begin
                    state_d = c_st_idle;
                end
            end
            default:    state_d = c_st_idle;
        endcase
    end

    // Output logic
    always_comb begin
        write_audio_out = 1'b0;
        sample_dropped  = 1'b0;
        if (state_q == c_st_wait) begin
            write_audio_out = audio_out_allowed;
            sample_dropped  = w_tick && !audio_out_allowed;
        end
    end

    assign w_start = w_tick && ((state_q == c_st_idle) || (state_q == c_st_wait));

    always_comb begin
        cnt_d = w_tick ? '0 : cnt_q + c_cnt_one;
        acc_d = acc_q;
        idx_d = idx_q;
        out_d = out_q;
        if (w_start) begin
            acc_d = '0;
            idx_d = '0;
        end else if (state_q == c_st_accum) begin
            acc_d = acc_q + w_term;
            idx_d = idx_q + c_idx_one;
        end
        if (state_q == c_st_sat) begin
            out_d = w_sat;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cnt_q <= '0;
            acc_q <= '0;
            idx_q <= '0;
            out_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            idx_q <= idx_d;
            out_q <= out_d;
        end
    end

    assign left_channel_audio_out  = out_q;
    assign right_channel_audio_out = out_q;

endmodule
`default_nettype wire

// File: tb/tb_voice_mix_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_voice_mix_feeder
// Brief    : Directed self-checking bench for voice_mix_feeder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_voice_mix_feeder;

    localparam int c_nv   = 10;
    localparam int c_div  = 20;
    localparam int c_step = 64;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [c_nv-1:0]      voice_en;
    logic [32*c_nv-1:0]   voice_samples;
    logic                 allowed;
    logic [31:0]          left_out, right_out;
    logic                 wr, drop;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    voice_mix_feeder #(
        .NUM_VOICES   (c_nv),
        .SAMPLE_DIV   (c_div),
        .ATTACK_STEP  (c_step),
        .RELEASE_STEP (c_step)
    ) dut (
        .CLOCK_50                (clk),
        .reset                   (reset),
        .voice_en                (voice_en),
        .voice_samples           (voice_samples),
        .audio_out_allowed       (allowed),
        .left_channel_audio_out  (left_out),
        .right_channel_audio_out (right_out),
        .write_audio_out         (wr),
        .sample_dropped          (drop)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic set_v(input int i, input logic [31:0] val);
        voice_samples[32*i +: 32] = val;
    endtask

    task automatic set_all(input logic [31:0] val);
        for (int i = 0; i < c_nv; i++) voice_samples[32*i +: 32] = val;
    endtask

    task automatic wait_write(output int wcyc);
        wcyc = -1;
        for (int n = 0; n < 40; n++) begin
            step();
            #1;
            if (wr === 1'b1) begin
                wcyc = cyc;
                break;
            end
        end
        if (wcyc < 0) begin
            total++;
            bad++;
            $error("FAIL write_timeout: observed=none expected=write within 40 cycles");
        end
    endtask

    int exp_ramp [10] = '{250, 500, 750, 1000, 1000, 750, 500, 250, 0, 0};

    initial begin
        int wc, prev, nwr, ndrop, dropk, wrk;
        prev = 0;

        reset    = 1'b1;
        allowed  = 1'b1;
        voice_en = 10'b00_0000_1000;
        for (int i = 0; i < c_nv; i++) set_v(i, 32'hDEAD_0000 | 32'(i));
        set_v(3, 32'd1000);
        repeat (3) step();
        #1;
        check("rst_left",  left_out,  32'd0);
        check("rst_right", right_out, 32'd0);
        check("rst_write", {31'd0, wr},   32'd0);
        check("rst_drop",  {31'd0, drop}, 32'd0);

        step();
        reset = 1'b0;
        cyc   = 0;

        // Ramp on voice 3; disabled voices carry nonzero garbage
        for (int n = 0; n < 10; n++) begin
            wait_write(wc);
            if (n == 0) check("first_write_cycle", 32'(wc), 32'd31);
            else        check("write_period", 32'(wc - prev), 32'(c_div));
            prev = wc;
            check("ramp_left",  left_out,  32'(exp_ramp[n]));
            check("ramp_right", right_out, 32'(exp_ramp[n]));
            if (n == 0) begin
                step();
                #1;
                check("write_one_cycle", {31'd0, wr}, 32'd0);
            end
            if (n == 4) voice_en = '0;
        end

        // Bring all voices to unity, then saturation patterns
        voice_en = '1;
        set_all(32'h7FFF_FFFF);
        repeat (4) wait_write(wc);
        check("sat_pos", left_out, 32'h7FFF_FFFF);

        set_all(32'h8000_0000);
        wait_write(wc);
        check("sat_neg", left_out, 32'h8000_0000);

        for (int i = 0; i < 5; i++) set_v(i, 32'd10_000_000);
        for (int i = 5; i < 9; i++) set_v(i, -32'sd10_000_000);
        set_v(9, 32'd7);
        wait_write(wc);
        check("mix_exact_left",  left_out,  32'd10_000_007);
        check("mix_exact_right", right_out, 32'd10_000_007);

        set_all(32'd0);
        set_v(0, 32'h7FFF_FFFF);
        set_v(1, 32'd1);
        wait_write(wc);
        check("sat_pos_by_one", left_out, 32'h7FFF_FFFF);

        set_all(32'd0);
        set_v(0, 32'h8000_0000);
        set_v(1, 32'hFFFF_FFFF);
        wait_write(wc);
        check("sat_neg_by_one", left_out, 32'h8000_0000);

        set_all(32'd0);
        set_v(0, 32'd10_000_000);
        wait_write(wc);
        check("unity_pass", left_out, 32'd10_000_000);

        // Backpressure across two ticks
        nwr = 0; ndrop = 0; dropk = -1; wrk = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k == 1) begin
                allowed = 1'b0;
                set_v(0, 32'd111);
            end
            if (k == 19) set_v(0, 32'd222);
            if (k == 31) allowed = 1'b1;
            #1;
            if (wr === 1'b1) begin
                nwr++;
                wrk = k;
            end
            if (drop === 1'b1) begin
                ndrop++;
                dropk = k;
            end
            if (k == 20) check("bp_first_out", left_out, 32'd111);
            if (k == 35) check("bp_hold_through_drop", left_out, 32'd111);
        end
        check("bp_drop_count",  32'(ndrop), 32'd1);
        check("bp_drop_cycle",  32'(dropk), 32'd28);
        check("bp_write_count", 32'(nwr),   32'd1);
        check("bp_write_cycle", 32'(wrk),   32'd40);
        check("bp_write_value", left_out,   32'd222);

        // Allowed rises on the same cycle as a tick in WAIT
        nwr = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k == 1) begin
                allowed = 1'b0;
                set_v(0, 32'd333);
            end
            if (k == 28) begin
                allowed = 1'b1;
                set_v(0, 32'd444);
            end
            #1;
            if (k < 28 && wr === 1'b1) nwr++;
            if (k == 28) begin
                check("co_write", {31'd0, wr},   32'd1);
                check("co_drop",  {31'd0, drop}, 32'd0);
                check("co_value", left_out,      32'd333);
            end
            if (k == 40) begin
                check("co_next_write", {31'd0, wr}, 32'd1);
                check("co_next_value", left_out,    32'd444);
            end
        end
        check("co_no_early_write", 32'(nwr), 32'd0);

        // Reset pulse in the middle of ACCUM
        for (int k = 1; k <= 13; k++) begin
            step();
            if (k == 12) reset = 1'b1;
            if (k == 13) reset = 1'b0;
            #1;
            if (k == 13) begin
                check("mid_rst_left",  left_out,      32'd0);
                check("mid_rst_right", right_out,     32'd0);
                check("mid_rst_write", {31'd0, wr},   32'd0);
                check("mid_rst_drop",  {31'd0, drop}, 32'd0);
            end
        end
        cyc = 0;
        nwr = 0; wrk = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            #1;
            if (wr === 1'b1) begin
                nwr++;
                if (wrk < 0) wrk = cyc;
            end
        end
        check("post_rst_write_count", 32'(nwr), 32'd1);
        check("post_rst_write_cycle", 32'(wrk), 32'd31);
        check("post_rst_gain_value",  left_out, 32'd111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
